ws2812_multi: RTL and testbench

//  Multi-lane WS2812/SK6812 LED-strip serialiser. Sits between the UART byte stream and the strip pins.
//  NUM_CH lanes share one valid/ready byte stream; each beat carries one byte per lane, sent MSB-first, lanes in lockstep.
//  Bit timing is in clk cycles, set by parameters. A double-buffered byte path gives gapless streaming.
//  An explicit s_last marker ends the frame and starts the reset/latch gap.

---
 rtl/ws2812_pkg.sv | 16 +
 rtl/ws2812_bit_timer.sv | 60 ++++++
 rtl/ws2812_multi.sv | 162 ++++++++++++++++
 tb/tb_ws2812_multi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, default 50 MHz timing and the timing-legality check for the WS2812 serialiser.
package ws2812_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StLatch} ws2812_state_e;

  localparam int unsigned DefT0hCyc    = 20;
  localparam int unsigned DefT1hCyc    = 40;
  localparam int unsigned DefTbitCyc   = 63;
  localparam int unsigned DefTresetCyc = 2500;

  function automatic bit timing_ok(input int unsigned t0h, input int unsigned t1h,
                                   input int unsigned tbit);
    return (t0h > 0) && (t0h < t1h) && (t1h < tbit);
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Bit-period and bit-index counters shared by all lanes; emits bit/byte strobes and
// the high-phase compares for a '0' and a '1' bit.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC  = DefT0hCyc,
  parameter int unsigned T1H_CYC  = DefT1hCyc,
  parameter int unsigned TBIT_CYC = DefTbitCyc
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic high0,
  output logic high1,
  output logic bit_end,
  output logic byte_end
);

  localparam int unsigned CycW = $clog2(TBIT_CYC);
  localparam logic [CycW-1:0] CycLast = CycW'(TBIT_CYC - 1);
  localparam logic [CycW-1:0] T0hVal  = CycW'(T0H_CYC);
  localparam logic [CycW-1:0] T1hVal  = CycW'(T1H_CYC);

  logic [CycW-1:0] cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;

  // Bit index wraps 0 -> 7 at a byte boundary, so a gapless reload needs no extra load.
  always_comb begin
    cyc_d = cyc_q;
    bit_d = bit_q;
    if (load) begin
      cyc_d = '0;
      bit_d = 3'd7;
    end else if (run) begin
      if (cyc_q == CycLast) begin
        cyc_d = '0;
        bit_d = bit_q - 3'd1;
      end else begin
        cyc_d = cyc_q + CycW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      bit_q <= 3'd7;
    end else begin
      cyc_q <= cyc_d;
      bit_q <= bit_d;
    end
  end

  assign high0    = (cyc_q < T0hVal);
  assign high1    = (cyc_q < T1hVal);
  assign bit_end  = run && (cyc_q == CycLast);
  assign byte_end = bit_end && (bit_q == 3'd0);

endmodule

// File: rtl/ws2812_multi.sv
// Multi-lane WS2812/SK6812 serialiser: staged byte stream in, lockstep NRZ pulses out.
// Optional per-lane brightness scaling is enabled with WS2812_BRIGHTNESS_EN.
module ws2812_multi
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned T0H_CYC    = DefT0hCyc,
  parameter int unsigned T1H_CYC    = DefT1hCyc,
  parameter int unsigned TBIT_CYC   = DefTbitCyc,
  parameter int unsigned TRESET_CYC = DefTresetCyc
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_CH*8-1:0]   s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [7:0]            bright,
  output logic [NUM_CH-1:0]     dout,
  output logic                  busy,
  output logic                  underrun
);

  if (!timing_ok(T0H_CYC, T1H_CYC, TBIT_CYC)) begin : g_bad_timing
    $error("ws2812_multi: require 0 < T0H_CYC < T1H_CYC < TBIT_CYC");
  end
  if (NUM_CH < 1 || NUM_CH > 16 || TRESET_CYC < 1) begin : g_bad_cfg
    $error("ws2812_multi: NUM_CH must be 1..16 and TRESET_CYC at least 1");
  end

  localparam int unsigned CntW = $clog2(TRESET_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TRESET_CYC - 1);

  ws2812_state_e         state_q, state_d;
  logic [NUM_CH*8-1:0]   s_scaled;
  logic [NUM_CH*8-1:0]   stg_data_q, sh_data_q, sh_next;
  logic                  stg_last_q, stg_valid_q, sh_last_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]     dout_q, dout_d;
  logic                  underrun_q, underrun_d;
  logic                  stg_take, timer_load, accept;
  logic                  high0, high1, bit_end, byte_end;

`ifdef WS2812_BRIGHTNESS_EN
  logic [8:0] bright_p1;
  assign bright_p1 = {1'b0, bright} + 9'd1;
  // 255 * 256 fits in 16 bits, so the truncated product is exact.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_scale
    logic [15:0] prod;
    assign prod = {8'd0, s_data[8*k +: 8]} * {7'd0, bright_p1};
    assign s_scaled[8*k +: 8] = 8'(prod >> 8);
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign s_scaled      = s_data;
`endif

  ws2812_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_bit_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .run      (state_q == StShift),
    .high0    (high0),
    .high1    (high1),
    .bit_end  (bit_end),
    .byte_end (byte_end)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stg_take   = 1'b0;
    timer_load = 1'b0;
    underrun_d = 1'b0;
    dout_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (stg_valid_q) begin
          stg_take   = 1'b1;
          timer_load = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        for (int k = 0; k < NUM_CH; k++) begin
          dout_d[k] = sh_data_q[8*k + 7] ? high1 : high0;
        end
        if (byte_end) begin
          if (sh_last_q) begin
            state_d = StLatch;
            cnt_d   = '0;
          end else if (stg_valid_q) begin
            stg_take = 1'b1;
          end else begin
            state_d    = StIdle;
            underrun_d = 1'b1;
          end
        end
      end
      StLatch: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sh_next = sh_data_q;
    for (int k = 0; k < NUM_CH; k++) begin
      sh_next[8*k +: 8] = {sh_data_q[8*k +: 7], 1'b0};
    end
  end

  assign s_ready = !stg_valid_q || stg_take;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      stg_data_q  <= '0;
      stg_last_q  <= 1'b0;
      stg_valid_q <= 1'b0;
      sh_data_q   <= '0;
      sh_last_q   <= 1'b0;
      cnt_q       <= '0;
      dout_q      <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      underrun_q <= underrun_d;
      if (accept) begin
        stg_data_q  <= s_scaled;
        stg_last_q  <= s_last;
        stg_valid_q <= 1'b1;
      end else if (stg_take) begin
        stg_valid_q <= 1'b0;
      end
      if (stg_take) begin
        sh_data_q <= stg_data_q;
        sh_last_q <= stg_last_q;
      end else if (bit_end) begin
        sh_data_q <= sh_next;
      end
    end
  end

  assign dout     = dout_q;
  assign busy     = (state_q != StIdle);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ws2812_multi.sv
// Randomised self-checking bench for ws2812_multi (2 lanes, short bit timing).
module tb_ws2812_multi;

  localparam int unsigned NCh    = 2;
  localparam int unsigned T0h    = 2;
  localparam int unsigned T1h    = 5;
  localparam int unsigned Tbit   = 8;
  localparam int unsigned Treset = 20;
  localparam int unsigned Bound  = 3000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCh*8-1:0]  s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [7:0]        bright = 8'hFF;
  logic [NCh-1:0]    dout;
  logic              busy;
  logic              underrun;

  ws2812_multi #(
    .NUM_CH     (NCh),
    .T0H_CYC    (T0h),
    .T1H_CYC    (T1h),
    .TBIT_CYC   (Tbit),
    .TRESET_CYC (Treset)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .bright   (bright),
    .dout     (dout),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc_no = 0;
  int          last_acc = 0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted byte becomes 8 high pulses per lane, MSB first,
  // '1' lasting T1h cycles and '0' lasting T0h.
  bit exp_q[NCh][$];
  int rise_q0[$];
  logic [NCh-1:0] prev = '0;
  int hi_len[NCh];
  int ur_cnt = 0;
  int ur_cyc = 0;

  function automatic logic [7:0] scale(input logic [7:0] b);
`ifdef WS2812_BRIGHTNESS_EN
    int unsigned p;
    p = (int'(b) * (int'(bright) + 1)) / 256;
    return 8'(p);
`else
    return b;
`endif
  endfunction

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev = '0;
      for (int k = 0; k < NCh; k++) exp_q[k].delete();
    end else begin
      if (underrun === 1'b1) begin
        ur_cnt++;
        ur_cyc = cyc_no;
      end
      for (int k = 0; k < NCh; k++) begin
        if (dout[k] && !prev[k]) begin
          hi_len[k] = 1;
          if (k == 0) rise_q0.push_back(cyc_no);
        end else if (dout[k]) begin
          hi_len[k]++;
        end else if (prev[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("unexpected_pulse_lane%0d", k), hi_len[k], 0);
          end else begin
            bit b;
            b = exp_q[k].pop_front();
            check($sformatf("high_len_lane%0d", k), hi_len[k], b ? T1h : T0h);
          end
        end
      end
      prev = dout;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [NCh*8-1:0] d, input logic last);
    int w;
    logic [7:0] sb;
    w = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && w < Bound) begin
      @(negedge clk);
      w++;
    end
    check("accept_in_bound", 32'(w < Bound), 1);
    last_acc = cyc_no + 1;
    for (int k = 0; k < NCh; k++) begin
      sb = scale(d[8*k +: 8]);
      for (int i = 7; i >= 0; i--) exp_q[k].push_back(sb[i]);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy || exp_q[0].size() != 0 || exp_q[1].size() != 0) && w < Bound);
    check(tag, 32'(w < Bound), 1);
  endtask

  task automatic wait_busy_fall(output int fall);
    int w;
    w = 0;
    while (busy !== 1'b1 && w < Bound) begin @(negedge clk); w++; end
    while (busy !== 1'b0 && w < Bound) begin @(negedge clk); w++; end
    fall = cyc_no;
    check("busy_fall_in_bound", 32'(w < Bound), 1);
  endtask

  task automatic check_rise(input string tag, input int idx, input int exp_cyc);
    if (rise_q0.size() > idx) check(tag, rise_q0[idx], exp_cyc);
    else check({tag, "_missing"}, rise_q0.size(), idx + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, fall, rq, ur0, n;
    logic [15:0] d;

    #23;
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", s_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    bright = 8'($urandom);
    repeat (2) @(negedge clk);

    // Single beat, lane0 0xA5, lane1 0x0F, then the latch gap.
    rise_q0.delete();
    send(16'h0FA5, 1'b1);
    acc = last_acc;
    wait_busy_fall(fall);
    check("t1_first_rise", rise_q0[0], acc + 2);
    check("t1_busy_fall", fall, acc + 1 + 8 * Tbit + Treset);
    check("t1_queue0_empty", exp_q[0].size(), 0);
    check("t1_queue1_empty", exp_q[1].size(), 0);

    // Three back-to-back beats: 24 contiguous bit periods.
    rise_q0.delete();
    ur0 = ur_cnt;
    for (int i = 0; i < 3; i++) send(16'($urandom), 1'(i == 2));
    wait_idle("t2_idle");
    check("t2_rise_count", rise_q0.size(), 24);
    check("t2_span", rise_q0[rise_q0.size()-1] - rise_q0[0], 23 * Tbit);
    check("t2_no_underrun", ur_cnt - ur0, 0);

    // Late second beat: one underrun pulse, then restart two cycles after acceptance.
    ur0 = ur_cnt;
    send(16'($urandom), 1'b0);
    acc = last_acc;
    begin
      int w;
      w = 0;
      while (ur_cnt == ur0 && w < Bound) begin @(negedge clk); w++; end
    end
    check("t3_underrun_cycle", ur_cyc, acc + 1 + 8 * Tbit);
    check("t3_dout_low", dout, 0);
    repeat (2) @(negedge clk);
    rq = rise_q0.size();
    send(16'($urandom), 1'b1);
    acc = last_acc;
    wait_idle("t3_idle");
    check("t3_underrun_once", ur_cnt - ur0, 1);
    check_rise("t3_restart_rise", rq, acc + 2);

    // Beat during the latch gap is held until the gap ends.
    send(16'($urandom), 1'b1);
    acc = last_acc;
    while (cyc_no < acc + 1 + 8 * Tbit + 5) @(negedge clk);
    check("t4_in_latch", busy, 1);
    rq = rise_q0.size();
    send(16'($urandom), 1'b1);
    check("t4_ready_low", s_ready, 0);
    wait_idle("t4_idle");
    check_rise("t4_first_rise", rq, acc + 1 + 8 * Tbit + Treset + 2);

    // Asynchronous reset during the high phase of a '1' bit with a byte staged.
    d = 16'($urandom) | 16'h0080;
    send(d, 1'b0);
    acc = last_acc;
    send(16'($urandom), 1'b1);
    while (cyc_no < acc + 4) @(negedge clk);
    check("t5_high_before_rst", dout[0], 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_dout", dout, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", s_ready, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rq = rise_q0.size();
    send(16'($urandom), 1'b1);
    acc = last_acc;
    wait_idle("t5_idle");
    check_rise("t5_rise_after_rst", rq, acc + 2);

`ifdef WS2812_BRIGHTNESS_EN
    bright = 8'd127;
    send(16'hFFFF, 1'b1);
    wait_idle("t6_half_idle");
    bright = 8'd255;
    send(16'hFFFF, 1'b1);
    wait_idle("t6_full_idle");
`endif

    // Random frames with occasional stalls between beats.
    for (int f = 0; f < 4; f++) begin
      bright = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
        send(16'($urandom), 1'(i == n - 1));
      end
      wait_idle("rand_idle");
      check("rand_dout_idle", dout, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
